// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch / prefetch unit.
// NOP is the canonical addi x0,x0,0 that IF/ID inserts when it squashes a slot.
package fetch_pkg;

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [XLEN-1:0] NOP = 32'h0000_0013;

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/fetch_queue.sv
// Small synchronous FIFO holding {instruction, pc} pairs between imem and IF/ID.
// Clear wins over push and pop; a pop frees its slot for a same-cycle push.
module fetch_queue #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    push,
  input  logic                    pop,
  input  logic                    clear,
  input  logic [WIDTH-1:0]        push_data,
  output logic                    full,
  output logic                    empty,
  output logic [WIDTH-1:0]        head,
  output logic [$clog2(DEPTH):0]  count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    rd_ptr_q;
  logic [AW-1:0]    wr_ptr_q;
  logic [AW:0]      count_q;
  logic             do_push;
  logic             do_pop;

  assign do_pop  = pop && (count_q != '0);
  assign do_push = push && ((count_q != FULL_COUNT) || do_pop);

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      count_q <= count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  assign head  = mem_q[rd_ptr_q];
  assign full  = (count_q == FULL_COUNT);
  assign empty = (count_q == '0);
  assign count = count_q;

endmodule

// File: rtl/fetch_prefetch_unit.sv
// Instruction fetch stage: credit-limited sequential prefetch into a small queue,
// with decode stall and branch redirect (old in-flight responses are dropped).
module fetch_prefetch_unit #(
  parameter int unsigned      XLEN     = fetch_pkg::XLEN,
  parameter int unsigned      DEPTH    = 4,
  parameter logic [XLEN-1:0]  RESET_PC = fetch_pkg::RESET_PC_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  output logic             imem_req_valid,
  output logic [XLEN-1:0]  imem_req_addr,
  input  logic             imem_req_ready,
  input  logic             imem_rsp_valid,
  input  logic [XLEN-1:0]  imem_rsp_data,
  input  logic             redirect,
  input  logic [XLEN-1:0]  redirect_pc,
  input  logic             stall,
  output logic             inst_valid,
  output logic [XLEN-1:0]  inst,
  output logic [XLEN-1:0]  inst_pc
);

  import fetch_pkg::*;

  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam logic [CW:0] DEPTH_W = (CW+1)'(DEPTH);

  fetch_state_e     state_q, state_d;
  logic [XLEN-1:0]  fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0]  resp_pc_q, resp_pc_d;
  logic [XLEN-1:0]  target_pc;
  logic [CW-1:0]    outstanding_q, outstanding_d;
  logic [CW-1:0]    drop_q, drop_d;
  logic [CW-1:0]    q_count;
  logic             q_full, q_empty, q_push, q_pop;
  logic [2*XLEN-1:0] q_head;
  logic             credit_ok;
  logic             fire;
  logic             unused_redirect_bits;

  assign unused_redirect_bits = ^redirect_pc[1:0];
  assign target_pc = {redirect_pc[XLEN-1:2], 2'b00};

  // In-flight plus buffered fetches may never exceed the queue size, so every
  // returning response is guaranteed a free slot.
  assign credit_ok = ({1'b0, outstanding_q} + {1'b0, q_count}) < DEPTH_W;
  assign fire      = imem_req_valid && imem_req_ready;
  assign q_push    = imem_rsp_valid && (drop_q == '0) && !redirect;
  assign q_pop     = inst_valid && !stall && !redirect;

  assign outstanding_d = outstanding_q + CW'(fire) - CW'(imem_rsp_valid);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (redirect) begin
      state_d = (outstanding_d != '0) ? FLUSH : RUN;
    end else if ((state_q == FLUSH) && (drop_q == '0)) begin
      state_d = RUN;
    end
  end

  always_comb begin
    imem_req_valid = 1'b0;
    if (!rst && (state_q == RUN) && credit_ok) begin
      imem_req_valid = 1'b1;
    end
  end

  // A redirect treats everything already requested, including this cycle's
  // fire, as stale; a response landing this cycle has already been retired.
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    resp_pc_d  = resp_pc_q;
    drop_d     = drop_q;
    if (redirect) begin
      fetch_pc_d = target_pc;
      resp_pc_d  = target_pc;
      drop_d     = outstanding_d;
    end else begin
      if (fire) begin
        fetch_pc_d = fetch_pc_q + XLEN'(4);
      end
      if (q_push) begin
        resp_pc_d = resp_pc_q + XLEN'(4);
      end
      if (imem_rsp_valid && (drop_q != '0)) begin
        drop_d = drop_q - CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q    <= RESET_PC;
      resp_pc_q     <= RESET_PC;
      outstanding_q <= '0;
      drop_q        <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      resp_pc_q     <= resp_pc_d;
      outstanding_q <= outstanding_d;
      drop_q        <= drop_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(q_push && q_full && !q_pop));
    end
  end

  fetch_queue #(
    .DEPTH (DEPTH),
    .WIDTH (2*XLEN)
  ) u_queue (
    .clk       (clk),
    .rst       (rst),
    .push      (q_push),
    .pop       (q_pop),
    .clear     (redirect),
    .push_data ({imem_rsp_data, resp_pc_q}),
    .full      (q_full),
    .empty     (q_empty),
    .head      (q_head),
    .count     (q_count)
  );

  assign imem_req_addr = fetch_pc_q;
  assign inst_valid    = !rst && !q_empty;
  assign inst          = inst_valid ? q_head[2*XLEN-1:XLEN] : '0;
  assign inst_pc       = inst_valid ? q_head[XLEN-1:0] : '0;

endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// Directed bench for fetch_prefetch_unit: a latency-configurable in-order imem
// model, a pop monitor, and one task per scenario with hand-computed PCs.
module tb_fetch_prefetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        stall;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;

  int errors = 0;
  int checks = 0;
  int lat = 1;
  int cycleCnt = 0;

  logic [31:0] pendAddr[$];
  int          pendDue[$];
  logic [31:0] logPc[$];
  logic [31:0] logInst[$];

  fetch_prefetch_unit dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (imem_req_valid),
    .imem_req_addr  (imem_req_addr),
    .imem_req_ready (imem_req_ready),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect       (redirect),
    .redirect_pc    (redirect_pc),
    .stall          (stall),
    .inst_valid     (inst_valid),
    .inst           (inst),
    .inst_pc        (inst_pc)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] instOf(input logic [31:0] a);
    return a ^ 32'h1357_9BDF;
  endfunction

  // In-order imem: a request accepted at the end of cycle c is answered in cycle c+lat.
  always @(posedge clk) begin
    if (rst) begin
      pendAddr.delete();
      pendDue.delete();
    end else if (imem_req_valid && imem_req_ready) begin
      pendAddr.push_back(imem_req_addr);
      pendDue.push_back(cycleCnt + lat);
    end
    cycleCnt++;
    #1;
    if (pendAddr.size() > 0 && pendDue[0] <= cycleCnt) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = instOf(pendAddr.pop_front());
      void'(pendDue.pop_front());
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
    end
  end

  // Record every instruction IF/ID actually takes.
  always @(negedge clk) begin
    if (!rst && inst_valid && !stall && !redirect) begin
      logPc.push_back(inst_pc);
      logInst.push_back(inst);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic quiesce();
    imem_req_ready = 1'b0;
    stall = 1'b0;
    redirect = 1'b0;
    repeat (10) step();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) step();
    @(negedge clk);
    checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("[TB] FAIL rst_req_valid: got %b want 0", imem_req_valid); end
    checks++; if (inst_valid !== 1'b0) begin errors++; $display("[TB] FAIL rst_inst_valid: got %b want 0", inst_valid); end
    checks++; if (inst !== 32'h0) begin errors++; $display("[TB] FAIL rst_inst: got %h want 0", inst); end
    checks++; if (inst_pc !== 32'h0) begin errors++; $display("[TB] FAIL rst_inst_pc: got %h want 0", inst_pc); end
    step();
    rst = 1'b0;
    @(negedge clk);
    checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0) begin errors++; $display("[TB] FAIL first_req: got v=%b a=%h want v=1 a=00000000", imem_req_valid, imem_req_addr); end
    checks++; if (inst_valid !== 1'b0) begin errors++; $display("[TB] FAIL c1_inst_valid: got %b want 0", inst_valid); end
    step();
    @(negedge clk);
    checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h4) begin errors++; $display("[TB] FAIL second_req: got v=%b a=%h want v=1 a=00000004", imem_req_valid, imem_req_addr); end
    checks++; if (inst_valid !== 1'b0) begin errors++; $display("[TB] FAIL c2_inst_valid: got %b want 0", inst_valid); end
    for (int i = 0; i < 3; i++) begin
      step();
      @(negedge clk);
      checks++;
      if (inst_valid !== 1'b1 || inst_pc !== 32'(4*i) || inst !== instOf(32'(4*i))) begin
        errors++;
        $display("[TB] FAIL stream_c%0d: got v=%b pc=%h inst=%h want v=1 pc=%h inst=%h", i+3, inst_valid, inst_pc, inst, 32'(4*i), instOf(32'(4*i)));
      end
    end
  endtask

  task automatic test_stall();
    step();
    stall = 1'b1;
    logPc.delete(); logInst.delete();
    @(negedge clk);
    checks++; if (inst_valid !== 1'b1 || inst_pc !== 32'hC) begin errors++; $display("[TB] FAIL stall_head: got v=%b pc=%h want v=1 pc=0000000c", inst_valid, inst_pc); end
    repeat (3) step();
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("[TB] FAIL stall_credit_%0d: got req_valid=%b want 0", i, imem_req_valid); end
      checks++; if (inst_valid !== 1'b1 || inst_pc !== 32'hC) begin errors++; $display("[TB] FAIL stall_hold_%0d: got v=%b pc=%h want v=1 pc=0000000c", i, inst_valid, inst_pc); end
      step();
    end
    stall = 1'b0;
    repeat (11) step();
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (i >= logPc.size()) begin
        errors++; $display("[TB] FAIL stall_release[%0d]: got nothing want pc=%h", i, 32'hC + 32'(4*i));
      end else if (logPc[i] !== 32'hC + 32'(4*i) || logInst[i] !== instOf(32'hC + 32'(4*i))) begin
        errors++; $display("[TB] FAIL stall_release[%0d]: got pc=%h inst=%h want pc=%h", i, logPc[i], logInst[i], 32'hC + 32'(4*i));
      end
    end
  endtask

  task automatic test_redirect();
    quiesce();
    lat = 3;
    imem_req_ready = 1'b1;
    step();
    step();
    redirect = 1'b1;
    redirect_pc = 32'h0000_0103;
    step();
    redirect = 1'b0;
    logPc.delete(); logInst.delete();
    @(negedge clk);
    checks++; if (imem_req_valid !== 1'b0 || inst_valid !== 1'b0) begin errors++; $display("[TB] FAIL redir_flush: got req_valid=%b inst_valid=%b want 0 0", imem_req_valid, inst_valid); end
    repeat (15) step();
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (i >= logPc.size()) begin
        errors++; $display("[TB] FAIL redir_seq[%0d]: got nothing want pc=%h", i, 32'h100 + 32'(4*i));
      end else if (logPc[i] !== 32'h100 + 32'(4*i) || logInst[i] !== instOf(32'h100 + 32'(4*i))) begin
        errors++; $display("[TB] FAIL redir_seq[%0d]: got pc=%h inst=%h want pc=%h", i, logPc[i], logInst[i], 32'h100 + 32'(4*i));
      end
    end
    begin
      int bad = 0;
      foreach (logPc[i]) if (logPc[i] < 32'h100) bad++;
      checks++; if (bad != 0) begin errors++; $display("[TB] FAIL redir_stale: got %0d old PCs want 0", bad); end
    end
  endtask

  task automatic test_redirect_same_cycle();
    quiesce();
    lat = 3;
    imem_req_ready = 1'b1;
    step();
    step();
    step();
    redirect = 1'b1;
    redirect_pc = 32'h0000_0180;
    step();
    redirect = 1'b0;
    logPc.delete(); logInst.delete();
    @(negedge clk);
    checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("[TB] FAIL same_flush: got req_valid=%b want 0", imem_req_valid); end
    repeat (15) step();
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (i >= logPc.size()) begin
        errors++; $display("[TB] FAIL same_seq[%0d]: got nothing want pc=%h", i, 32'h180 + 32'(4*i));
      end else if (logPc[i] !== 32'h180 + 32'(4*i)) begin
        errors++; $display("[TB] FAIL same_seq[%0d]: got pc=%h want pc=%h", i, logPc[i], 32'h180 + 32'(4*i));
      end
    end
  endtask

  task automatic test_back_to_back();
    quiesce();
    lat = 3;
    imem_req_ready = 1'b1;
    step();
    step();
    redirect = 1'b1;
    redirect_pc = 32'h0000_0200;
    step();
    redirect_pc = 32'h0000_0300;
    step();
    redirect = 1'b0;
    logPc.delete(); logInst.delete();
    @(negedge clk);
    checks++; if (imem_req_valid !== 1'b0 || inst_valid !== 1'b0) begin errors++; $display("[TB] FAIL b2b_flush: got req_valid=%b inst_valid=%b want 0 0", imem_req_valid, inst_valid); end
    repeat (15) step();
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (i >= logPc.size()) begin
        errors++; $display("[TB] FAIL b2b_seq[%0d]: got nothing want pc=%h", i, 32'h300 + 32'(4*i));
      end else if (logPc[i] !== 32'h300 + 32'(4*i) || logInst[i] !== instOf(32'h300 + 32'(4*i))) begin
        errors++; $display("[TB] FAIL b2b_seq[%0d]: got pc=%h inst=%h want pc=%h", i, logPc[i], logInst[i], 32'h300 + 32'(4*i));
      end
    end
    begin
      int bad = 0;
      foreach (logPc[i]) if (logPc[i] < 32'h300 || logPc[i] >= 32'h400) bad++;
      checks++; if (bad != 0) begin errors++; $display("[TB] FAIL b2b_stale: got %0d foreign PCs want 0", bad); end
    end
  endtask

  task automatic test_wrap();
    quiesce();
    lat = 1;
    redirect = 1'b1;
    redirect_pc = 32'hFFFF_FFFA;
    step();
    redirect = 1'b0;
    imem_req_ready = 1'b1;
    logPc.delete(); logInst.delete();
    @(negedge clk);
    checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'hFFFF_FFF8) begin errors++; $display("[TB] FAIL wrap_req0: got v=%b a=%h want v=1 a=fffffff8", imem_req_valid, imem_req_addr); end
    step();
    @(negedge clk);
    checks++; if (imem_req_addr !== 32'hFFFF_FFFC) begin errors++; $display("[TB] FAIL wrap_req1: got a=%h want fffffffc", imem_req_addr); end
    step();
    @(negedge clk);
    checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0) begin errors++; $display("[TB] FAIL wrap_req2: got v=%b a=%h want v=1 a=00000000", imem_req_valid, imem_req_addr); end
    repeat (6) step();
    for (int i = 0; i < 4; i++) begin
      logic [31:0] exp;
      exp = 32'hFFFF_FFF8 + 32'(4*i);
      checks++;
      if (i >= logPc.size()) begin
        errors++; $display("[TB] FAIL wrap_seq[%0d]: got nothing want pc=%h", i, exp);
      end else if (logPc[i] !== exp || logInst[i] !== instOf(exp)) begin
        errors++; $display("[TB] FAIL wrap_seq[%0d]: got pc=%h inst=%h want pc=%h", i, logPc[i], logInst[i], exp);
      end
    end
  endtask

  task automatic test_reset_mid();
    step();
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (imem_req_valid !== 1'b0 || inst_valid !== 1'b0 || inst !== 32'h0 || inst_pc !== 32'h0) begin
      errors++; $display("[TB] FAIL midrst_outputs: got rv=%b iv=%b inst=%h pc=%h want all 0", imem_req_valid, inst_valid, inst, inst_pc);
    end
    step();
    step();
    rst = 1'b0;
    logPc.delete(); logInst.delete();
    @(negedge clk);
    checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0) begin errors++; $display("[TB] FAIL midrst_req: got v=%b a=%h want v=1 a=00000000", imem_req_valid, imem_req_addr); end
    checks++; if (inst_valid !== 1'b0) begin errors++; $display("[TB] FAIL midrst_inst_valid: got %b want 0", inst_valid); end
    repeat (6) step();
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (i >= logPc.size()) begin
        errors++; $display("[TB] FAIL midrst_seq[%0d]: got nothing want pc=%h", i, 32'(4*i));
      end else if (logPc[i] !== 32'(4*i)) begin
        errors++; $display("[TB] FAIL midrst_seq[%0d]: got pc=%h want pc=%h", i, logPc[i], 32'(4*i));
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    stall = 1'b0;
    redirect = 1'b0;
    redirect_pc = '0;
    imem_req_ready = 1'b1;
    imem_rsp_valid = 1'b0;
    imem_rsp_data = '0;
    test_reset();
    test_stall();
    test_redirect();
    test_redirect_same_cycle();
    test_back_to_back();
    test_wrap();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no finish want finish before 200000");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
